mmu_8722: RTL and testbench
===========================

// Module: mmu_8722
// PURPOSE
//  C128 memory management unit, the upstream end of the memory-map interface decoded by the PLA.
//  Holds the CPU-visible MMU register file at $D500-$D50B and $FF00-$FF04.
//  Drives the mode/select lines ms0..ms3 and z80en into the PLA.
//  Performs page-0/1 relocation, RAM bank selection and shared-RAM forcing, driving translated address ta[15:8] and ram_bank.
// PARAMETERS
//  VERSION    8'h20   value returned on reads of $D50B
//  BANK_BITS  2       width of ram_bank; also the number of low P0H/P1H bits used
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   reset: asynchronous, active-low
//  a         in   16  CPU address (valid when aec=1)
//  d_in      in   8   CPU write data
//  rw        in   1   1=read, 0=write
//  aec       in   1   1=CPU cycle, 0=VIC cycle
//  bus_stb   in   1   1-clk pulse marking the end of a valid CPU cycle; commits writes
//  game_in   in   1   cartridge /GAME level (reflected in MCR reads)
//  exrom_in  in   1   cartridge /EXROM level (reflected in MCR reads)
//  k4080     in   1   40/80 key level (reflected in MCR reads)
//  d_out     out  8   register read data
//  d_oe      out  1   d_out valid; comb: aec & rw & visible-register hit
//  ms0..ms3  out  1   memory-select lines to the PLA
//  z80en     out  1   MCR[0]; 0 = Z80 owns the bus
//  fsdir     out  1   MCR[3], fast-serial direction
//  ta        out  8   translated A15..A8
//  ram_bank  out  BANK_BITS  RAM bank (CAS select)
//  vic_bank  out  2   RCR[7:6]
// BEHAVIOUR
//  Reset values (all async on rst_n=0, including pending latches):
//   CR=00, PCRA..D=00, MCR=00, RCR=00, P0L=00, P0H=00, P1L=01, P1H=00.
//   Consequences: z80en=0, ms3=1, ms2=0.
//  Register map; accesses commit only on bus_stb & aec:
//   $D500/$FF00  CR, read/write.
//   $D501-$D504  PCRA-D, read/write.
//   $FF01-$FF04  LCRA-D: any write copies PCRx into CR (data ignored); a read returns PCRx.
//   $D505        MCR: a write stores bits 6, 3 and 0.
//                Read = {k4080, MCR6, exrom_in, game_in, MCR3, 2'b11, MCR0}.
//   $D506        RCR: a write stores bits 7:6 and 3:0; bits 5:4 read as 11.
//   $D507-$D50A  P0L, P0H, P1L, P1H.
//                A PxH write goes to a pending latch only.
//                A PxL write loads PxL and copies the pending latch into PxH in the same clk.
//                PxH reads return the committed value.
//   $D50B        VERSION; read-only, writes ignored.
//   $D50C-$D5FF and $FF05+: no response (d_oe=0).
//  Visibility:
//   $D5xx is visible only when CR[0]=0 (I/O enabled).
//   $FFxx is visible regardless of CR.
//  C64 lock:
//   Once MCR[6]=1, all registers are hidden and no writes are accepted until rst_n.
//   While locked: ms3=0, ta=a[15:8], ram_bank=0.
//  Write latency: a register written on bus_stb at edge N drives its outputs from edge N onward (1 clk).
//  Select outputs (comb):
//   ms3 = ~MCR[6]; ms2 = CR[0].
//   {ms0,ms1} by region: $4000-7FFF = CR[1] ? 11 : 00; $8000-BFFF = {CR[3],CR[2]};
//   $C000-FFFF = {CR[5],CR[4]}; $0000-3FFF or aec=0 = 11.
//  Translation (aec=1, unlocked); p = a[15:8]:
//   p==00 -> ta=P0L, bank=P0H[1:0].
//   p==01 -> ta=P1L, bank=P1H[1:0].
//   p==P0L and CR[7:6]==P0H[1:0] -> ta=00 (swap). Same rule for P1 -> ta=01. P0 wins if both match.
//   Otherwise ta=p, bank=CR[7:6].
//   Shared RAM: limit L = {04,10,20,40}[RCR[1:0]].
//    RCR[2] & p<L, or RCR[3] & p>=100-L, forces bank 0.
//    Pages 00/01 are exempt from forcing.
//  VIC cycle (aec=0): ta=a[15:8], ram_bank=RCR[7:6], no register access.
//  Reset asserted mid-cycle aborts any write and clears all pending PxH latches.
// TESTING
//  Reset -> z80en=0, ms3=1, CR/MCR/RCR read 00, $D50B reads 20, P1L reads 01.
//  Write $D501=3F, write $FF01 (data 00) -> $FF00 reads 3F; a=$8000 -> {ms0,ms1}=11.
//  Write P0H=01 then read P0H -> 00. Write P0L=40 -> a=$0012: ta=40, ram_bank=1.
//   Also with CR=00, a=$4012 -> ta=40 (P0H bank 1 != CR bank 0, so no swap).
//  RCR=05 (4K bottom), CR=40, a=$0C00 -> ram_bank=0; a=$1000 -> ram_bank=1.
//  MCR=41 -> ms3=0; later write $D500=FF is ignored and d_oe stays 0; pulse rst_n -> ms3=1.
//  CR=01 -> read $D505 gives d_oe=0; read $FF00 still gives 01 with d_oe=1.

Source files
------------

// File: rtl/mmu_8722.sv
// rtl/mmu_8722.sv - C128 MMU: register file, PLA mode/select lines, page relocation and RAM banking
module mmu_8722 #(
  parameter logic [7:0] VERSION   = 8'h20,
  parameter int         BANK_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          a,
  input  logic [7:0]           d_in,
  input  logic                 rw,
  input  logic                 aec,
  input  logic                 bus_stb,
  input  logic                 game_in,
  input  logic                 exrom_in,
  input  logic                 k4080,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  output logic                 ms0,
  output logic                 ms1,
  output logic                 ms2,
  output logic                 ms3,
  output logic                 z80en,
  output logic                 fsdir,
  output logic [7:0]           ta,
  output logic [BANK_BITS-1:0] ram_bank,
  output logic [1:0]           vic_bank
);

  logic [7:0] cr_q;
  logic [7:0] pcr_q [4];
  logic [7:0] mcr_q;
  logic [7:0] rcr_q;
  logic [7:0] p0l_q, p0h_q, p1l_q, p1h_q;
  logic [7:0] p0h_pend_q, p1h_pend_q;

  logic [7:0] p, lo;
  logic [1:0] pcr_idx;
  logic       locked, d5_sel, ff_sel, hit, wr_en;

  assign p       = a[15:8];
  assign lo      = a[7:0];
  // $xx01..$xx04 map onto PCRA..D; $xx04 wraps to index 3
  assign pcr_idx = lo[1:0] - 2'd1;
  assign locked  = mcr_q[6];
  assign d5_sel  = (p == 8'hD5) && (lo <= 8'h0B) && !cr_q[0];
  assign ff_sel  = (p == 8'hFF) && (lo <= 8'h04);
  assign hit     = (d5_sel || ff_sel) && !locked;
  assign wr_en   = bus_stb && aec && !rw && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q       <= 8'h00;
      for (int i = 0; i < 4; i++) pcr_q[i] <= 8'h00;
      mcr_q      <= 8'h00;
      rcr_q      <= 8'h00;
      p0l_q      <= 8'h00;
      p0h_q      <= 8'h00;
      p1l_q      <= 8'h01;
      p1h_q      <= 8'h00;
      p0h_pend_q <= 8'h00;
      p1h_pend_q <= 8'h00;
    end else if (wr_en) begin
      if (ff_sel) begin
        if (lo == 8'h00) cr_q <= d_in;
        else             cr_q <= pcr_q[pcr_idx];
      end else begin
        case (lo)
          8'h00: cr_q <= d_in;
          8'h01, 8'h02, 8'h03, 8'h04: pcr_q[pcr_idx] <= d_in;
          8'h05: mcr_q <= d_in & 8'h49;
          8'h06: rcr_q <= d_in & 8'hCF;
          8'h07: begin
            p0l_q <= d_in;
            p0h_q <= p0h_pend_q;
          end
          8'h08: p0h_pend_q <= d_in;
          8'h09: begin
            p1l_q <= d_in;
            p1h_q <= p1h_pend_q;
          end
          8'h0A: p1h_pend_q <= d_in;
          default: ;
        endcase
      end
    end
  end

  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    if (ff_sel) begin
      rd_data = (lo == 8'h00) ? cr_q : pcr_q[pcr_idx];
    end else begin
      case (lo)
        8'h00:                      rd_data = cr_q;
        8'h01, 8'h02, 8'h03, 8'h04: rd_data = pcr_q[pcr_idx];
        8'h05: rd_data = mcr_q | {k4080, 1'b0, exrom_in, game_in, 4'b0110};
        8'h06: rd_data = rcr_q | 8'h30;
        8'h07: rd_data = p0l_q;
        8'h08: rd_data = p0h_q;
        8'h09: rd_data = p1l_q;
        8'h0A: rd_data = p1h_q;
        8'h0B: rd_data = VERSION;
        default: rd_data = 8'h00;
      endcase
    end
  end

  assign d_oe  = aec && rw && hit;
  assign d_out = d_oe ? rd_data : 8'h00;

  assign ms3      = ~mcr_q[6];
  assign ms2      = cr_q[0];
  assign z80en    = mcr_q[0];
  assign fsdir    = mcr_q[3];
  assign vic_bank = rcr_q[7:6];

  always_comb begin
    {ms0, ms1} = 2'b11;
    if (aec) begin
      case (p[7:6])
        2'b01:   {ms0, ms1} = cr_q[1] ? 2'b11 : 2'b00;
        2'b10:   {ms0, ms1} = {cr_q[3], cr_q[2]};
        2'b11:   {ms0, ms1} = {cr_q[5], cr_q[4]};
        default: {ms0, ms1} = 2'b11;
      endcase
    end
  end

  logic [BANK_BITS-1:0] cr_bank, rcr_bank, p0_bank, p1_bank;
  logic [8:0]           share_lim;
  logic                 share_force;

  assign cr_bank  = BANK_BITS'(cr_q[7:6]);
  assign rcr_bank = BANK_BITS'(rcr_q[7:6]);
  assign p0_bank  = p0h_q[BANK_BITS-1:0];
  assign p1_bank  = p1h_q[BANK_BITS-1:0];

  always_comb begin
    case (rcr_q[1:0])
      2'b00:   share_lim = 9'h004;
      2'b01:   share_lim = 9'h010;
      2'b10:   share_lim = 9'h020;
      default: share_lim = 9'h040;
    endcase
  end

  assign share_force = (rcr_q[2] && ({1'b0, p} < share_lim)) ||
                       (rcr_q[3] && ({1'b0, p} >= (9'h100 - share_lim)));

  // Page 0/1 relocation is a two-way swap: the target page maps back onto 00/01
  always_comb begin
    ta       = p;
    ram_bank = cr_bank;
    if (!aec) begin
      ram_bank = rcr_bank;
    end else if (locked) begin
      ram_bank = '0;
    end else if (p == 8'h00) begin
      ta       = p0l_q;
      ram_bank = p0_bank;
    end else if (p == 8'h01) begin
      ta       = p1l_q;
      ram_bank = p1_bank;
    end else begin
      if (p == p0l_q && cr_bank == p0_bank)      ta = 8'h00;
      else if (p == p1l_q && cr_bank == p1_bank) ta = 8'h01;
      if (share_force) ram_bank = '0;
    end
  end

endmodule

// File: tb/tb_mmu_8722.sv
// tb/tb_mmu_8722.sv - directed self-checking bench for mmu_8722
module tb_mmu_8722;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic        rw = 1'b1;
  logic        aec = 1'b1;
  logic        bus_stb = 1'b0;
  logic        game_in = 1'b0;
  logic        exrom_in = 1'b1;
  logic        k4080 = 1'b1;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        ms0, ms1, ms2, ms3, z80en, fsdir;
  logic [7:0]  ta;
  logic [1:0]  ram_bank;
  logic [1:0]  vic_bank;

  int n_tests = 0;
  int n_fail  = 0;

  mmu_8722 dut (
    .clk(clk), .rst_n(rst_n), .a(a), .d_in(d_in), .rw(rw), .aec(aec),
    .bus_stb(bus_stb), .game_in(game_in), .exrom_in(exrom_in), .k4080(k4080),
    .d_out(d_out), .d_oe(d_oe), .ms0(ms0), .ms1(ms1), .ms2(ms2), .ms3(ms3),
    .z80en(z80en), .fsdir(fsdir), .ta(ta), .ram_bank(ram_bank), .vic_bank(vic_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    a = addr; d_in = data; rw = 1'b0; aec = 1'b1; bus_stb = 1'b1;
    @(posedge clk);
    #1;
    bus_stb = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic oe_exp, input logic [7:0] d_exp);
    @(negedge clk);
    a = addr; rw = 1'b1; aec = 1'b1;
    #1;
    check({tag, "_oe"}, {15'd0, d_oe}, {15'd0, oe_exp});
    if (oe_exp) check(tag, {8'd0, d_out}, {8'd0, d_exp});
  endtask

  task automatic xlat(input string tag, input logic [15:0] addr, input logic vic, input logic [7:0] ta_exp, input logic [1:0] bank_exp);
    @(negedge clk);
    a = addr; rw = 1'b1; aec = ~vic;
    #1;
    check({tag, "_ta"}, {8'd0, ta}, {8'd0, ta_exp});
    check({tag, "_bank"}, {14'd0, ram_bank}, {14'd0, bank_exp});
    aec = 1'b1;
  endtask

  task automatic msel(input string tag, input logic [15:0] addr, input logic vic, input logic [1:0] exp);
    @(negedge clk);
    a = addr; rw = 1'b1; aec = ~vic;
    #1;
    check(tag, {14'd0, ms0, ms1}, {14'd0, exp});
    aec = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_z80en", {15'd0, z80en}, 16'd0);
    check("rst_ms3", {15'd0, ms3}, 16'd1);
    check("rst_ms2", {15'd0, ms2}, 16'd0);
    rd("rst_cr", 16'hD500, 1'b1, 8'h00);
    rd("rst_mcr", 16'hD505, 1'b1, 8'hA6);
    rd("rst_rcr", 16'hD506, 1'b1, 8'h30);
    rd("rst_ver", 16'hD50B, 1'b1, 8'h20);
    rd("rst_p1l", 16'hD509, 1'b1, 8'h01);
    rd("nohit_d50c", 16'hD50C, 1'b0, 8'h00);
    rd("nohit_ff05", 16'hFF05, 1'b0, 8'h00);

    wr(16'hD501, 8'h3F);
    wr(16'hFF01, 8'h00);
    rd("lcr_cr", 16'hFF00, 1'b1, 8'h3F);
    rd("lcr_read", 16'hFF01, 1'b1, 8'h3F);
    rd("io_hidden", 16'hD501, 1'b0, 8'h00);
    msel("ms_8000", 16'h8000, 1'b0, 2'b11);
    msel("ms_c000", 16'hC000, 1'b0, 2'b11);
    msel("ms_4000_cr1", 16'h4000, 1'b0, 2'b11);
    wr(16'hFF00, 8'h00);
    msel("ms_4000", 16'h4000, 1'b0, 2'b00);
    msel("ms_0000", 16'h0000, 1'b0, 2'b11);
    msel("ms_vic", 16'h4000, 1'b1, 2'b11);

    wr(16'hD508, 8'h01);
    rd("p0h_pend", 16'hD508, 1'b1, 8'h00);
    wr(16'hD507, 8'h40);
    rd("p0h_commit", 16'hD508, 1'b1, 8'h01);
    xlat("p0_reloc", 16'h0012, 1'b0, 8'h40, 2'd1);
    xlat("no_swap", 16'h4012, 1'b0, 8'h40, 2'd0);
    xlat("p1_page", 16'h0134, 1'b0, 8'h01, 2'd0);
    wr(16'hD500, 8'h40);
    xlat("swap", 16'h4012, 1'b0, 8'h00, 2'd1);

    wr(16'hD506, 8'h05);
    rd("rcr_rd", 16'hD506, 1'b1, 8'h35);
    xlat("shr_0c", 16'h0C00, 1'b0, 8'h0C, 2'd0);
    xlat("shr_10", 16'h1000, 1'b0, 8'h10, 2'd1);
    xlat("shr_exempt", 16'h0012, 1'b0, 8'h40, 2'd1);
    wr(16'hD506, 8'h0A);
    xlat("shr_top_in", 16'hE000, 1'b0, 8'hE0, 2'd0);
    xlat("shr_top_out", 16'hDF00, 1'b0, 8'hDF, 2'd1);
    wr(16'hD506, 8'hC5);
    xlat("vic", 16'h1234, 1'b1, 8'h12, 2'd3);
    check("vic_bank", {14'd0, vic_bank}, 16'd3);

    wr(16'hFF00, 8'h01);
    rd("cr01_d505", 16'hD505, 1'b0, 8'h00);
    rd("cr01_ff00", 16'hFF00, 1'b1, 8'h01);
    check("cr01_ms2", {15'd0, ms2}, 16'd1);
    wr(16'hFF00, 8'h00);

    wr(16'hD505, 8'h41);
    check("lock_ms3", {15'd0, ms3}, 16'd0);
    check("lock_z80en", {15'd0, z80en}, 16'd1);
    wr(16'hD500, 8'hFF);
    rd("lock_hidden", 16'hFF00, 1'b0, 8'h00);
    check("lock_cr_kept", {15'd0, ms2}, 16'd0);
    xlat("lock_xlat", 16'h0012, 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("unlock_ms3", {15'd0, ms3}, 16'd1);
    check("unlock_z80en", {15'd0, z80en}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    wr(16'hD508, 8'h03);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr(16'hD507, 8'h55);
    rd("pend_cleared", 16'hD508, 1'b1, 8'h00);
    rd("p0l_after", 16'hD507, 1'b1, 8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
